// File: rtl/calc_sequencer_if.sv
// calc_sequencer_if: keypad-in / display-out bundle of the calculator sequencer.
interface calc_sequencer_if #(parameter int WIDTH = 10);
  logic [3:0]       key_code_i;
  logic             key_valid_i;
  logic [WIDTH-1:0] display_value_o;
  logic             display_neg_o;
  logic             error_o;
  logic             busy_o;
  logic [2:0]       state_dbg_o;
  modport master (output key_code_i, key_valid_i,
                  input  display_value_o, display_neg_o, error_o, busy_o, state_dbg_o);
  modport slave  (input  key_code_i, key_valid_i,
                  output display_value_o, display_neg_o, error_o, busy_o, state_dbg_o);
endinterface

// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad calculator control FSM with two-operand entry and shift-add multiply.
module calc_sequencer #(
  parameter int WIDTH      = 10,
  parameter int MAX_VALUE  = 999,
  parameter int MAX_DIGITS = 3
) (
  input logic clk_i,
  input logic rst_ni,
  calc_sequencer_if.slave bus
);
  localparam int CW  = $clog2(MAX_DIGITS + 1);
  localparam int MCW = $clog2(WIDTH);
  typedef enum logic [2:0] {ENTRY_A = 3'd0, OP_WAIT, ENTRY_B, EXEC_ADDSUB, EXEC_MUL, RESULT, ERROR} state_e;
  typedef enum logic [1:0] {ADD, SUB, MUL} op_e;
  state_e             state_q, state_d, fin_state;
  op_e                op_q, op_d, key_op;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, disp_q, disp_d, a_app, b_app, diff, fin_disp;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [MCW-1:0]     mcnt_q, mcnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, prod, res;
  logic [WIDTH:0]     r_as;
  logic               neg_q, neg_d, err_q, err_d, busy, take, is_dig, is_op, is_clr, is_eq, room, ovf, fin_neg;
  logic [3:0]         k;
  assign k      = bus.key_code_i;
  assign busy   = state_q == EXEC_ADDSUB || state_q == EXEC_MUL;
  assign take   = bus.key_valid_i && !busy;
  assign is_dig = k <= 4'd9;
  assign is_op  = k == 4'hA || k == 4'hB || k == 4'hC;
  assign is_clr = k == 4'hD;
  assign is_eq  = k == 4'hE;
  assign key_op = k == 4'hA ? ADD : k == 4'hB ? SUB : MUL;
  assign room   = cnt_q < CW'(MAX_DIGITS);
  assign a_app  = a_q * WIDTH'(10) + WIDTH'(k);
  assign b_app  = b_q * WIDTH'(10) + WIDTH'(k);
  assign diff   = b_q > a_q ? b_q - a_q : a_q - b_q;
  assign r_as   = op_q == ADD ? {1'b0, a_q} + {1'b0, b_q} : {1'b0, diff};
  // One multiplier bit per cycle; the last bit's partial sum feeds the result check directly.
  assign prod   = acc_q + (b_q[mcnt_q] ? {{WIDTH{1'b0}}, a_q} << mcnt_q : '0);
  assign res    = state_q == EXEC_MUL ? prod : {{(WIDTH-1){1'b0}}, r_as};
  assign ovf    = res > (2*WIDTH)'(MAX_VALUE);
  assign fin_state = ovf ? ERROR : RESULT;
  assign fin_disp  = ovf ? '0 : res[WIDTH-1:0];
  assign fin_neg   = !ovf && op_q == SUB && b_q > a_q;
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    neg_d   = neg_q;
    err_d   = err_q;
    acc_d   = acc_q;
    mcnt_d  = mcnt_q;
    if (take && is_clr) begin
      state_d = ENTRY_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = ADD;
      cnt_d   = '0;
      disp_d  = '0;
      neg_d   = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ENTRY_A:
          if (take && is_dig && room) begin
            a_d    = a_app;
            cnt_d  = cnt_q + 1'b1;
            disp_d = a_app;
          end else if (take && is_op) begin
            op_d    = key_op;
            b_d     = '0;
            cnt_d   = '0;
            state_d = OP_WAIT;
          end
        OP_WAIT:
          if (take && is_dig) begin
            b_d     = WIDTH'(k);
            cnt_d   = CW'(1);
            disp_d  = WIDTH'(k);
            state_d = ENTRY_B;
          end else if (take && is_op) op_d = key_op;
        ENTRY_B:
          if (take && is_dig && room) begin
            b_d    = b_app;
            cnt_d  = cnt_q + 1'b1;
            disp_d = b_app;
          end else if (take && is_eq) begin
            state_d = op_q == MUL ? EXEC_MUL : EXEC_ADDSUB;
            acc_d   = '0;
            mcnt_d  = '0;
          end
        EXEC_ADDSUB: begin
          state_d = fin_state;
          disp_d  = fin_disp;
          neg_d   = fin_neg;
          err_d   = ovf;
        end
        EXEC_MUL: begin
          acc_d  = prod;
          mcnt_d = mcnt_q + 1'b1;
          if (mcnt_q == MCW'(WIDTH - 1)) begin
            state_d = fin_state;
            disp_d  = fin_disp;
            neg_d   = fin_neg;
            err_d   = ovf;
          end
        end
        RESULT:
          if (take && is_dig) begin
            a_d     = WIDTH'(k);
            cnt_d   = CW'(1);
            neg_d   = 1'b0;
            disp_d  = WIDTH'(k);
            state_d = ENTRY_A;
          end else if (take && is_op && !neg_q) begin
            a_d     = disp_q;
            op_d    = key_op;
            b_d     = '0;
            cnt_d   = '0;
            state_d = OP_WAIT;
          end
        ERROR: ;
        default: state_d = ENTRY_A;
      endcase
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= ENTRY_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= ADD;
      cnt_q   <= '0;
      disp_q  <= '0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      acc_q   <= '0;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
      mcnt_q  <= mcnt_d;
    end
  assign bus.display_value_o = disp_q;
  assign bus.display_neg_o   = neg_q;
  assign bus.error_o         = err_q;
  assign bus.busy_o          = busy;
  assign bus.state_dbg_o     = state_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed plan plus random keys against a key-level calculator model.
module tb_calc_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int m_s, m_a, m_b, m_op, m_cnt, m_disp, m_neg, m_err;
  calc_sequencer_if bus ();
  calc_sequencer dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".disp"}, int'(bus.display_value_o), m_disp);
    chk({tag, ".neg"}, int'(bus.display_neg_o), m_neg);
    chk({tag, ".err"}, int'(bus.error_o), m_err);
    chk({tag, ".state"}, int'(bus.state_dbg_o), m_s);
    chk({tag, ".busy"}, int'(bus.busy_o), 0);
  endtask

  task automatic m_rst();
    m_s = 0; m_a = 0; m_b = 0; m_op = 10; m_cnt = 0; m_disp = 0; m_neg = 0; m_err = 0;
  endtask

  // States: 0 entry A, 1 operator wait, 2 entry B, 3 add/sub run, 4 multiply run, 5 result, 6 error.
  task automatic m_key(input int k);
    bit dig, op;
    dig = k <= 9;
    op = k >= 10 && k <= 12;
    if (k == 13) m_rst();
    else if (m_s == 0) begin
      if (dig && m_cnt < 3) begin m_a = m_a * 10 + k; m_cnt++; m_disp = m_a; end
      else if (op) begin m_op = k; m_b = 0; m_cnt = 0; m_s = 1; end
    end else if (m_s == 1) begin
      if (dig) begin m_b = k; m_cnt = 1; m_disp = k; m_s = 2; end
      else if (op) m_op = k;
    end else if (m_s == 2) begin
      if (dig && m_cnt < 3) begin m_b = m_b * 10 + k; m_cnt++; m_disp = m_b; end
      else if (k == 14) m_s = m_op == 12 ? 4 : 3;
    end else if (m_s == 5) begin
      if (dig) begin m_a = k; m_cnt = 1; m_neg = 0; m_disp = k; m_s = 0; end
      else if (op && !m_neg) begin m_a = m_disp; m_op = k; m_b = 0; m_cnt = 0; m_s = 1; end
    end
  endtask

  task automatic m_exec();
    int r;
    r = m_op == 10 ? m_a + m_b : m_op == 11 ? (m_a > m_b ? m_a - m_b : m_b - m_a) : m_a * m_b;
    if (r > 999) begin m_s = 6; m_disp = 0; m_neg = 0; m_err = 1; end
    else begin m_s = 5; m_disp = r; m_neg = m_op == 11 && m_b > m_a; end
  endtask

  task automatic press(input int k, input bit poke);
    int n, lat;
    @(negedge clk);
    bus.key_code_i = 4'(k);
    bus.key_valid_i = 1'b1;
    @(negedge clk);
    bus.key_valid_i = 1'b0;
    m_key(k);
    if (m_s == 3 || m_s == 4) begin
      lat = m_s == 3 ? 1 : 10;
      n = 0;
      while (bus.busy_o === 1'b1 && n < 40) begin
        n++;
        bus.key_valid_i = poke;
        bus.key_code_i = 4'($urandom_range(0, 9));
        @(negedge clk);
      end
      bus.key_valid_i = 1'b0;
      chk("busy_cycles", n, lat);
      m_exec();
    end
    chk_all("key");
  endtask

  task automatic keys(input string s, input bit poke);
    int k;
    for (int i = 0; i < s.len(); i++) begin
      k = s[i] >= "A" ? s[i] - "A" + 10 : s[i] - "0";
      press(k, poke);
    end
  endtask

  initial begin
    bus.key_code_i = 4'h0;
    bus.key_valid_i = 1'b0;
    m_rst();
    repeat (3) @(negedge clk);
    chk_all("reset");
    rst_n = 1'b1;
    keys("123", 0);
    chk("plan1_123", int'(bus.display_value_o), 123);
    keys("4", 0);
    chk("plan1_4th", int'(bus.display_value_o), 123);
    keys("D12A34E", 0);
    chk("plan2_sum", int'(bus.display_value_o), 46);
    chk("plan2_state", int'(bus.state_dbg_o), 5);
    keys("D5B12E", 0);
    chk("plan3_mag", int'(bus.display_value_o), 7);
    chk("plan3_neg", int'(bus.display_neg_o), 1);
    keys("AE", 0);
    chk("plan3_hold", int'(bus.state_dbg_o), 5);
    keys("D25C39E", 1);
    chk("plan4_prod", int'(bus.display_value_o), 975);
    keys("A2E", 0);
    chk("plan4_chain", int'(bus.display_value_o), 977);
    keys("D500A500E", 0);
    chk("plan5_err", int'(bus.error_o), 1);
    chk("plan5_state", int'(bus.state_dbg_o), 6);
    keys("7E", 0);
    chk("plan5_hold", int'(bus.state_dbg_o), 6);
    keys("D", 0);
    chk("plan5_clr", int'(bus.error_o), 0);
    keys("D99C99", 0);
    @(negedge clk);
    bus.key_code_i = 4'hE;
    bus.key_valid_i = 1'b1;
    @(negedge clk);
    bus.key_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("plan6_busy4", int'(bus.busy_o), 1);
    rst_n = 1'b0;
    m_rst();
    #1;
    chk_all("plan6_async");
    @(negedge clk);
    rst_n = 1'b1;
    keys("1A1E", 0);
    chk("plan6_after", int'(bus.display_value_o), 2);
    keys("D", 0);
    for (int i = 0; i < 400; i++) press(int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Control FSM for the keypad calculator. Consumes decoded keycodes from the keypad encoder, assembles two decimal operands, and sequences add, subtract and multiply.
- Multiply runs as a multi-cycle shift-add.
- Drives a 10-bit binary value plus sign and error flags into the bin2bcd / seven-segment display path.
- Sits between keypad_encoder and bin2bcd_10bit in the top level.

Parameters:
- WIDTH, 10, width of operands, accumulator and display_value.
- MAX_VALUE, 999, largest displayable magnitude; a larger result raises error.
- MAX_DIGITS, 3, maximum decimal digits accepted per operand.

Ports:
- Clk  input  1  system clock (12 MHz board clock).
- reset  input  1  asynchronous, active-low reset.
- key_code  input  4  keycode from the keypad encoder, valid only when key_valid=1.
- key_valid  input  1  single-cycle pulse, one per debounced key press.
- display_value  output  WIDTH  magnitude to show (to bin2bcd binIN).
- display_neg  output  1  result is negative (drives minus LED / decimal point).
- error  output  1  overflow; held until clear.
- busy  output  1  execution in progress; keys ignored.
- state_dbg  output  3  current FSM state encoding, for LEDs.

Behaviour:
- Reset (async, reset=0) sets:
  - outputs: display_value=0, display_neg=0, error=0, busy=0, state=ENTRY_A.
  - internal registers: operand A=0, operand B=0, op=ADD, digit count=0.
- Key map:
  - 0x0-0x9: digits.
  - 0xA: add. 0xB: subtract. 0xC: multiply.
  - 0xD: clear. 0xE: equals. 0xF: ignored.
- Keys are acted on only at a Clk edge where key_valid=1 and busy=0. Keys arriving while busy=1 are dropped, not queued.
- Clear (0xD) is honoured in every state except EXEC_MUL and EXEC_ADDSUB. It returns the FSM to the reset values of all registers and outputs.
- ENTRY_A, digit d:
  - If count<MAX_DIGITS: A <= A*10+d, count+1.
  - Else the digit is ignored.
  - display_value tracks A.
- ENTRY_A, operator key: latch op, clear B and count, go to OP_WAIT. display_value keeps A.
- ENTRY_A, equals: ignored.
- OP_WAIT:
  - Digit: B <= d, count=1, go to ENTRY_B; display tracks B.
  - Another operator: replaces op.
  - Equals: ignored.
- ENTRY_B:
  - Digits as in ENTRY_A, applied to B.
  - Operator: ignored (no chaining).
  - Equals: go to EXEC_ADDSUB if op is ADD/SUB, or EXEC_MUL if op is MUL.
- EXEC_ADDSUB (one cycle, busy=1):
  - ADD: R = A+B.
  - SUB: R = |A-B|, with neg = (B>A).
  - Computed at WIDTH+1 bits.
- EXEC_MUL (busy=1):
  - Shift-add over the WIDTH bits of B, one bit per cycle, 2*WIDTH-bit accumulator.
  - Exactly WIDTH cycles in EXEC_MUL.
- Latency:
  - Equals sampled at edge N.
  - ADD/SUB: busy=1 during cycle N..N+1; result registered at edge N+1.
  - MUL: busy=1 for WIDTH cycles; result registered at edge N+WIDTH.
  - busy deasserts in the same cycle the result appears.
- Result check:
  - If R > MAX_VALUE: go to ERROR with display_value=0, display_neg=0, error=1.
  - Else go to RESULT with display_value=R and display_neg set as computed.
- RESULT:
  - Digit d: start a new A = d, count=1, neg=0, go to ENTRY_A.
  - Operator with display_neg=0: A <= R, latch op, go to OP_WAIT.
  - Operator with display_neg=1: ignored.
  - Equals: ignored (no repeat).
- ERROR: only clear is accepted; everything else is ignored.
- Asynchronous reset mid-EXEC_MUL aborts immediately to reset values; no partial result is visible.
- state_dbg encoding: ENTRY_A=0, OP_WAIT=1, ENTRY_B=2, EXEC_ADDSUB=3, EXEC_MUL=4, RESULT=5, ERROR=6.

Test Plan:
- Keys 1,2,3,4 -> display_value=123 after third key; 4th digit ignored, display stays 123.
- 1,2,A,3,4,E -> busy high 1 cycle, display_value=46, display_neg=0, state RESULT.
- 5,B,1,2,E -> display_value=7, display_neg=1; then key A -> ignored, state stays RESULT.
- 2,5,C,3,9,E -> busy high exactly 10 cycles, display_value=975; digit keys pulsed mid-busy have no effect.
- 5,0,0,A,5,0,0,E -> error=1, display_value=0, state ERROR; keys 7, E ignored; D -> ENTRY_A, error=0.
- 9,9,C,9,9,E with reset pulled low at busy cycle 4 -> all outputs 0, state ENTRY_A immediately (async); after release, 1,A,1,E -> 2.
